// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: arbitrates the single write port of the register file
// between the WB stage (pipe_*) and a buffered auxiliary writer (aux_*).
// WB has priority. Aux writes queue in a small FIFO and drain into idle port
// cycles. WB is stalled when the FIFO head has waited STARVE_LIMIT cycles, or
// when a buffered aux entry targets the same register (WAW ordering).
//
// Optional feature: define RF_ARB_BYPASS_EN to let an aux request write the
// port in the same cycle when the FIFO is empty and WB is idle.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   pipe_we/pipe_reg/pipe_data      WB write request
//   pipe_stall                      WB must hold its request this cycle
//   aux_valid/aux_reg/aux_data      aux write request
//   aux_ready                       aux request accepted when valid && ready
//   reg_write/write_reg/write_data  register file write port
//   pending_mask                    registers targeted by buffered aux writes
module rf_write_arbiter #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pipe_we,
    input  logic [ADDR_W-1:0]    pipe_reg,
    input  logic [DATA_W-1:0]    pipe_data,
    output logic                 pipe_stall,
    input  logic                 aux_valid,
    output logic                 aux_ready,
    input  logic [ADDR_W-1:0]    aux_reg,
    input  logic [DATA_W-1:0]    aux_data,
    output logic                 reg_write,
    output logic [ADDR_W-1:0]    write_reg,
    output logic [DATA_W-1:0]    write_data,
    output logic [2**ADDR_W-1:0] pending_mask
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_W-1:0]    fifo_reg  [DEPTH];
    logic [DATA_W-1:0]    fifo_data [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [WAIT_W-1:0]    wait_cnt;

    logic                 fifo_empty;
    logic                 fifo_full;
    logic [2**ADDR_W-1:0] pend;
    logic [PTR_W-1:0]     offs;
    logic                 stall_conflict;
    logic                 stall_starve;
    logic                 pipe_go;
    logic                 pop;
    logic                 push;
    logic                 bypass;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(DEPTH));

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        pend = '0;
        offs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr;
            if (CNT_W'(offs) < count) begin
                pend[fifo_reg[i]] = 1'b1;
            end
        end
    end

    assign stall_conflict = pipe_we && !fifo_empty && pend[pipe_reg];
    assign stall_starve   = pipe_we && !fifo_empty && (wait_cnt >= WAIT_W'(STARVE_LIMIT));

    assign pipe_stall   = !reset && (stall_conflict || stall_starve);
    assign pipe_go      = !reset && pipe_we && !pipe_stall;
    assign pop          = !reset && !pipe_go && !fifo_empty;
    assign aux_ready    = !reset && !fifo_full;
    assign pending_mask = reset ? '0 : pend;

`ifdef RF_ARB_BYPASS_EN
    assign bypass = !reset && fifo_empty && !pipe_we && aux_valid;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed request is consumed by the port and never enqueued.
    assign push = aux_valid && aux_ready && !bypass;

    always_comb begin
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        if (pipe_go) begin
            reg_write  = 1'b1;
            write_reg  = pipe_reg;
            write_data = pipe_data;
        end else if (pop) begin
            reg_write  = 1'b1;
            write_reg  = fifo_reg[rd_ptr];
            write_data = fifo_data[rd_ptr];
        end else if (bypass) begin
            reg_write  = 1'b1;
            write_reg  = aux_reg;
            write_data = aux_data;
        end
    end

    // Storage needs no reset; validity is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= aux_reg;
            fifo_data[wr_ptr] <= aux_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (fifo_empty || pop) begin
                wait_cnt <= '0;
            end else if (wait_cnt < WAIT_W'(STARVE_LIMIT)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by a
// randomized run checked against a queue-based reference model.
module tb_rf_write_arbiter;

    localparam int LIMIT = 4;
    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        pipe_we;
    logic [1:0]  pipe_reg;
    logic [15:0] pipe_data;
    logic        pipe_stall;
    logic        aux_valid;
    logic        aux_ready;
    logic [1:0]  aux_reg;
    logic [15:0] aux_data;
    logic        reg_write;
    logic [1:0]  write_reg;
    logic [15:0] write_data;
    logic [3:0]  pending_mask;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]  r;
        logic [15:0] d;
    } ent_t;

    rf_write_arbiter #(
        .DATA_W(16),
        .ADDR_W(2),
        .DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pipe_we(pipe_we),
        .pipe_reg(pipe_reg),
        .pipe_data(pipe_data),
        .pipe_stall(pipe_stall),
        .aux_valid(aux_valid),
        .aux_ready(aux_ready),
        .aux_reg(aux_reg),
        .aux_data(aux_data),
        .reg_write(reg_write),
        .write_reg(write_reg),
        .write_data(write_data),
        .pending_mask(pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_we   = 1'b0;
        pipe_reg  = 2'd0;
        pipe_data = 16'h0;
        aux_valid = 1'b0;
        aux_reg   = 2'd0;
        aux_data  = 16'h0;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (4) next_cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        aux_valid = 1'b1;
        aux_reg   = 2'd1;
        aux_data  = 16'hBEEF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({aux_ready, reg_write, pipe_stall, pending_mask, write_reg, write_data} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle=%0d got=%h exp=0", c,
                         {aux_ready, reg_write, pipe_stall, pending_mask, write_reg, write_data});
            end
            next_cycle();
        end
        reset = 1'b0;
        aux_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({aux_ready, reg_write, pending_mask} !== {1'b1, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", {aux_ready, reg_write, pending_mask},
                     {1'b1, 1'b0, 4'b0000});
        end
        next_cycle();
    endtask

    task automatic test_lone_aux();
        idle_inputs();
        aux_valid = 1'b1;
        aux_reg   = 2'd2;
        aux_data  = 16'h1234;
        @(negedge clk);
        checks++;
`ifdef RF_ARB_BYPASS_EN
        if ({aux_ready, reg_write, write_reg, write_data, pending_mask} !==
            {1'b1, 1'b1, 2'd2, 16'h1234, 4'b0000}) begin
`else
        if ({aux_ready, reg_write, write_reg, write_data, pending_mask} !==
            {1'b1, 1'b0, 2'd0, 16'h0000, 4'b0000}) begin
`endif
            errors++;
            $display("FAIL lone_aux_cycle0 got=%h", {aux_ready, reg_write, write_reg, write_data,
                     pending_mask});
        end
        next_cycle();
        aux_valid = 1'b0;
        @(negedge clk);
        checks++;
`ifdef RF_ARB_BYPASS_EN
        if ({reg_write, write_reg, write_data, pending_mask} !== {1'b0, 2'd0, 16'h0, 4'b0000}) begin
`else
        if ({reg_write, write_reg, write_data, pending_mask} !==
            {1'b1, 2'd2, 16'h1234, 4'b0100}) begin
`endif
            errors++;
            $display("FAIL lone_aux_cycle1 got=%h", {reg_write, write_reg, write_data,
                     pending_mask});
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({reg_write, pending_mask} !== {1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL lone_aux_cycle2 got=%b exp=00000", {reg_write, pending_mask});
        end
        drain();
    endtask

    task automatic test_starvation();
        idle_inputs();
        pipe_we   = 1'b1;
        pipe_reg  = 2'd3;
        pipe_data = 16'h3000;
        aux_valid = 1'b1;
        aux_reg   = 2'd1;
        aux_data  = 16'hAAAA;
        @(negedge clk);
        checks++;
        if ({reg_write, write_reg, write_data} !== {1'b1, 2'd3, 16'h3000}) begin
            errors++;
            $display("FAIL starve_push_cycle got=%h exp=%h", {reg_write, write_reg, write_data},
                     {1'b1, 2'd3, 16'h3000});
        end
        next_cycle();
        aux_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            pipe_data = 16'h3000 + 16'(k);
            @(negedge clk);
            checks++;
            if ({pipe_stall, reg_write, write_reg, write_data, pending_mask} !==
                {1'b0, 1'b1, 2'd3, pipe_data, 4'b0010}) begin
                errors++;
                $display("FAIL starve_wb_cycle%0d got=%h exp=%h", k,
                         {pipe_stall, reg_write, write_reg, write_data, pending_mask},
                         {1'b0, 1'b1, 2'd3, pipe_data, 4'b0010});
            end
            next_cycle();
        end
        pipe_data = 16'h3005;
        @(negedge clk);
        checks++;
        if ({pipe_stall, reg_write, write_reg, write_data} !== {1'b1, 1'b1, 2'd1, 16'hAAAA}) begin
            errors++;
            $display("FAIL starve_stall got=%h exp=%h", {pipe_stall, reg_write, write_reg,
                     write_data}, {1'b1, 1'b1, 2'd1, 16'hAAAA});
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({pipe_stall, reg_write, write_reg, write_data, pending_mask} !==
            {1'b0, 1'b1, 2'd3, 16'h3005, 4'b0000}) begin
            errors++;
            $display("FAIL starve_release got=%h", {pipe_stall, reg_write, write_reg, write_data,
                     pending_mask});
        end
        next_cycle();
        drain();
    endtask

    task automatic test_waw();
        logic [15:0] exp_d [3];
        logic        exp_s [3];
        exp_d[0] = 16'h0001; exp_d[1] = 16'h0003; exp_d[2] = 16'h0002;
        exp_s[0] = 1'b1;     exp_s[1] = 1'b1;     exp_s[2] = 1'b0;
        idle_inputs();
        pipe_we   = 1'b1;
        pipe_reg  = 2'd3;
        pipe_data = 16'h7777;
        aux_valid = 1'b1;
        aux_reg   = 2'd0;
        aux_data  = 16'h0001;
        next_cycle();
        aux_data  = 16'h0003;
        next_cycle();
        aux_valid = 1'b0;
        pipe_reg  = 2'd0;
        pipe_data = 16'h0002;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({pipe_stall, reg_write, write_reg, write_data} !==
                {exp_s[k], 1'b1, 2'd0, exp_d[k]}) begin
                errors++;
                $display("FAIL waw_cycle%0d got=%h exp=%h", k,
                         {pipe_stall, reg_write, write_reg, write_data},
                         {exp_s[k], 1'b1, 2'd0, exp_d[k]});
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_full();
        logic [15:0] got[$];
        logic        stalled;
        idle_inputs();
        pipe_we   = 1'b1;
        pipe_reg  = 2'd3;
        pipe_data = 16'h5000;
        for (int c = 0; c <= 6; c++) begin
            aux_valid = 1'b1;
            if (c == 0) begin
                aux_reg = 2'd1; aux_data = 16'h0A01;
            end else if (c == 1) begin
                aux_reg = 2'd2; aux_data = 16'h0B02;
            end else begin
                aux_reg = 2'd0; aux_data = 16'h0C03;
            end
            @(negedge clk);
            checks++;
            if (c <= 1) begin
                if (aux_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL full_ready_c%0d got=%b exp=1", c, aux_ready);
                end
            end else if (c <= 4) begin
                if ({aux_ready, pipe_stall} !== 2'b00) begin
                    errors++;
                    $display("FAIL full_backpressure_c%0d got=%b exp=00", c,
                             {aux_ready, pipe_stall});
                end
            end else if (c == 5) begin
                if ({aux_ready, pipe_stall, write_data, pending_mask} !==
                    {1'b0, 1'b1, 16'h0A01, 4'b0110}) begin
                    errors++;
                    $display("FAIL full_starve_pop got=%h", {aux_ready, pipe_stall, write_data,
                             pending_mask});
                end
            end else begin
                if ({aux_ready, pipe_stall, write_reg, write_data} !==
                    {1'b1, 1'b0, 2'd3, pipe_data}) begin
                    errors++;
                    $display("FAIL full_accept got=%h exp=%h", {aux_ready, pipe_stall, write_reg,
                             write_data}, {1'b1, 1'b0, 2'd3, pipe_data});
                end
            end
            stalled = pipe_stall;
            next_cycle();
            if (!stalled) pipe_data = pipe_data + 16'd1;
        end
        aux_valid = 1'b0;
        for (int k = 0; k < 30 && got.size() < 2; k++) begin
            @(negedge clk);
            if (reg_write && write_reg != 2'd3) got.push_back(write_data);
            stalled = pipe_stall;
            next_cycle();
            if (!stalled) pipe_data = pipe_data + 16'd1;
        end
        checks++;
        if (got.size() != 2) begin
            errors++;
            $display("FAIL full_drain_timeout got=%0d entries exp=2", got.size());
        end else if ({got[0], got[1]} !== {16'h0B02, 16'h0C03}) begin
            errors++;
            $display("FAIL full_order got=%h,%h exp=0b02,0c03", got[0], got[1]);
        end
        drain();
    endtask

    task automatic test_bypass();
        idle_inputs();
        aux_valid = 1'b1;
        aux_reg   = 2'd1;
        aux_data  = 16'h00FF;
        @(negedge clk);
        checks++;
`ifdef RF_ARB_BYPASS_EN
        if ({aux_ready, reg_write, write_reg, write_data, pending_mask} !==
            {1'b1, 1'b1, 2'd1, 16'h00FF, 4'b0000}) begin
`else
        if ({aux_ready, reg_write, pending_mask} !== {1'b1, 1'b0, 4'b0000}) begin
`endif
            errors++;
            $display("FAIL bypass_cycle0 got=%h", {aux_ready, reg_write, write_reg, write_data,
                     pending_mask});
        end
        next_cycle();
        aux_valid = 1'b0;
        @(negedge clk);
        checks++;
`ifdef RF_ARB_BYPASS_EN
        if ({reg_write, pending_mask} !== {1'b0, 4'b0000}) begin
`else
        if ({reg_write, write_reg, write_data, pending_mask} !==
            {1'b1, 2'd1, 16'h00FF, 4'b0010}) begin
`endif
            errors++;
            $display("FAIL bypass_cycle1 got=%h", {reg_write, write_reg, write_data,
                     pending_mask});
        end
        drain();
    endtask

    task automatic test_random();
        ent_t        q[$];
        int          w;
        logic        hold;
        logic        e_stall, e_ready, e_we, e_pop, byp;
        logic [1:0]  e_reg;
        logic [15:0] e_data;
        logic [3:0]  pend;
        logic        nonempty;
        ent_t        e;
        w    = 0;
        hold = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (!hold) begin
                pipe_we   = ($urandom_range(0, 3) != 0);
                pipe_reg  = 2'($urandom);
                pipe_data = 16'($urandom);
            end
            aux_valid = 1'($urandom);
            aux_reg   = 2'($urandom);
            aux_data  = 16'($urandom);
            reset     = ($urandom_range(0, 59) == 0);
            e_stall = 1'b0; e_ready = 1'b0; e_we = 1'b0; e_pop = 1'b0; byp = 1'b0;
            e_reg = 2'd0; e_data = 16'h0; pend = 4'b0;
            if (!reset) begin
                foreach (q[i]) pend[q[i].r] = 1'b1;
                e_stall = pipe_we && (q.size() > 0) && (pend[pipe_reg] || w >= LIMIT);
                e_ready = (q.size() < DEPTH);
`ifdef RF_ARB_BYPASS_EN
                byp = (q.size() == 0) && !pipe_we && aux_valid;
`endif
                if (pipe_we && !e_stall) begin
                    e_we = 1'b1; e_reg = pipe_reg; e_data = pipe_data;
                end else if (q.size() > 0) begin
                    e_we = 1'b1; e_reg = q[0].r; e_data = q[0].d; e_pop = 1'b1;
                end else if (byp) begin
                    e_we = 1'b1; e_reg = aux_reg; e_data = aux_data;
                end
            end
            @(negedge clk);
            checks++;
            if ({aux_ready, pipe_stall, reg_write, write_reg, write_data, pending_mask} !==
                {e_ready, e_stall, e_we, e_reg, e_data, pend}) begin
                errors++;
                $display("FAIL random_cycle%0d got=%h exp=%h", n,
                         {aux_ready, pipe_stall, reg_write, write_reg, write_data, pending_mask},
                         {e_ready, e_stall, e_we, e_reg, e_data, pend});
            end
            if (reset) begin
                q.delete();
                w = 0;
            end else begin
                nonempty = (q.size() > 0);
                if (e_pop) void'(q.pop_front());
                if (aux_valid && e_ready && !byp) begin
                    e.r = aux_reg;
                    e.d = aux_data;
                    q.push_back(e);
                end
                w = (!nonempty || e_pop) ? 0 : ((w < LIMIT) ? w + 1 : LIMIT);
            end
            hold = e_stall;
            next_cycle();
        end
        reset = 1'b0;
        drain();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_lone_aux();
        test_starvation();
        test_waw();
        test_full();
        test_bypass();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port of the 4x16 register file between two writers: the pipeline WB stage (`pipe_*`) and an auxiliary multi-cycle unit (`aux_*`, e.g. a multiplier/divider).
- Aux writes are buffered in a small FIFO. WB has priority on the port; aux entries drain into idle port cycles.
- Two mechanisms stall WB so aux writes cannot starve or be reordered: a starvation guard and a write-after-write (WAW) guard.
- Exports a pending-register mask so the ID stage can stall reads of registers that still have a buffered aux write.

Parameters:
- DATA_W, 16, write data width
- ADDR_W, 2, register address width (4 registers)
- DEPTH, 2, aux FIFO entries; power of two, >= 2
- STARVE_LIMIT, 4, cycles the FIFO head may wait before WB is stalled

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high reset
- pipe_we  in  1  WB stage write request
- pipe_reg  in  ADDR_W  WB destination register
- pipe_data  in  DATA_W  WB write data
- pipe_stall  out  1  WB must hold its request this cycle; write is not performed
- aux_valid  in  1  aux write request
- aux_ready  out  1  FIFO can accept; transfer occurs when valid && ready at posedge
- aux_reg  in  ADDR_W  aux destination register
- aux_data  in  DATA_W  aux write data
- reg_write  out  1  register file write enable
- write_reg  out  ADDR_W  register file write address
- write_data  out  DATA_W  register file write data
- pending_mask  out  2**ADDR_W  bit i = 1 when any FIFO entry targets register i

Behaviour:
- Reset (synchronous, takes effect at posedge while reset=1):
  - FIFO emptied; all pending aux entries are discarded.
  - Wait counter cleared.
  - While reset=1: aux_ready=0, reg_write=0, pipe_stall=0, pending_mask=0, write_reg=0, write_data=0.
- FIFO: count register, pointers wrap modulo DEPTH.
  - aux_ready = !reset && count<DEPTH.
  - Push on valid&&ready. Push and pop in the same cycle leave count unchanged.
- pending_mask: combinational OR over the valid FIFO entries, from current state only (an entry being pushed this cycle is not yet included).
- Port selection is combinational from current state and inputs; writes land at the same posedge.
  - stall_conflict = pipe_we && count>0 && pending_mask[pipe_reg]
  - stall_starve = pipe_we && count>0 && wait>=STARVE_LIMIT
  - pipe_stall = stall_conflict || stall_starve
  - If pipe_we && !pipe_stall: drive port from pipe_*; no pop.
  - Else if count>0: drive port from FIFO head; pop.
  - Else: reg_write=0, write_reg/write_data=0.
- Ordering:
  - A conflict stall persists, popping one entry per cycle, until no buffered entry targets pipe_reg.
  - Same-register aux entries always retire in FIFO order and before the stalled WB write.
- WB contract: while pipe_stall=1, WB holds pipe_we/pipe_reg/pipe_data unchanged next cycle.
- Wait counter:
  - Increments (saturating at STARVE_LIMIT) each cycle with count>0 and no pop.
  - Clears on any pop and whenever count==0.
- Latency: an aux entry pushed at edge N appears on the port no earlier than cycle N+1.
- Ignored inputs: pipe_reg/pipe_data when pipe_we=0; aux_reg/aux_data when no push.

Optional Feature:
- Macro: RF_ARB_BYPASS_EN
- Defined:
  - When count==0, pipe_we==0 and aux_valid==1, aux_* drives the port in the same cycle and the request is accepted without enqueueing (aux_ready=1).
  - pending_mask and the wait counter are unaffected.
- Undefined: every aux write passes through the FIFO (minimum latency 1 cycle).

Test Plan:
1. Reset: hold reset 2 cycles with aux_valid=1, then release -> during reset aux_ready=0, reg_write=0, pending_mask=0; first cycle after release aux_ready=1, FIFO empty.
2. Lone aux write: push r2=0x1234 at edge 0, pipe_we=0 -> cycle 1: reg_write=1, write_reg=2, write_data=0x1234, pending_mask=4'b0100; cycle 2: pending_mask=0, reg_write=0.
3. Starvation: FIFO holds r1=0xAAAA; pipe_we=1 to r3 every cycle with new data -> port shows r3 writes for 4 cycles; 5th cycle pipe_stall=1, port writes r1=0xAAAA; 6th cycle the held r3 write proceeds, pipe_stall=0.
4. WAW conflict: FIFO holds r0=0x0001 then r0=0x0003; pipe_we r0=0x0002 -> pipe_stall=1 for 2 cycles, port writes 0x0001 then 0x0003; third cycle writes 0x0002.
5. Full/backpressure: pipe_we=1 to r3 continuously; push 2 aux entries -> aux_ready=0 with count==2; held aux_valid is not lost; after the starvation pop aux_ready=1 and the third entry is accepted; data order preserved.
6. With RF_ARB_BYPASS_EN: FIFO empty, pipe_we=0, aux r1=0x00FF -> same cycle reg_write=1, write_reg=1, write_data=0x00FF, pending_mask stays 0. Without the macro, the write appears 1 cycle later.
